// File: rtl/pic_pkg.sv
// Shared PIC definitions: arbiter FSM states and the priority-order rotation helper.
package pic_pkg;

   typedef enum logic [1:0] {IDLE, REQ, ACKD} state_e;

   localparam int unsigned MAX_IRQ = 32;
   localparam int unsigned MAX_IDX_W = 5;

   // Reorders vec so bit 0 holds the highest-priority channel (base+1) and bit n-1 holds base.
   function automatic logic [MAX_IRQ-1:0] rot_left(input logic [MAX_IRQ-1:0] vec,
                                                   input int unsigned base,
                                                   input int unsigned n);
      logic [MAX_IRQ-1:0] res;
      int unsigned idx;
      res = '0;
      idx = 0;
      for (int unsigned i = 0; i < MAX_IRQ; i++) begin
         if (i < n) begin
            idx = base + 1 + i;
            if (idx >= n) idx = idx - n;
            res[i[MAX_IDX_W-1:0]] = vec[idx[MAX_IDX_W-1:0]];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/irq_priority_arbiter_if.sv
// Request/acknowledge/EOI bundle between the IRR/IMR and sequencer logic and the arbiter.
interface irq_priority_arbiter_if #(
   parameter int unsigned NUM_IRQ = 8,
   parameter int unsigned ID_W    = $clog2(NUM_IRQ)
);
   logic [NUM_IRQ-1:0] irr;
   logic [NUM_IRQ-1:0] imr;
   logic               special_mask_mode;
   logic               auto_eoi;
   logic               auto_rotate;
   logic               rotate_on_eoi;
   logic               eoi_nonspecific;
   logic               eoi_specific;
   logic [ID_W-1:0]    eoi_level;
   logic               set_priority;
   logic [ID_W-1:0]    priority_level;
   logic               ack;
   logic               int_out;
   logic               vector_valid;
   logic [ID_W-1:0]    vector_id;
   logic [NUM_IRQ-1:0] isr;
   logic [ID_W-1:0]    priority_base;

   modport master (
      output irr, imr, special_mask_mode, auto_eoi, auto_rotate, rotate_on_eoi,
             eoi_nonspecific, eoi_specific, eoi_level, set_priority, priority_level, ack,
      input  int_out, vector_valid, vector_id, isr, priority_base
   );

   modport slave (
      input  irr, imr, special_mask_mode, auto_eoi, auto_rotate, rotate_on_eoi,
             eoi_nonspecific, eoi_specific, eoi_level, set_priority, priority_level, ack,
      output int_out, vector_valid, vector_id, isr, priority_base
   );
endinterface

// File: rtl/rotating_priority_encoder.sv
// Finds the highest-priority set bit of vec, where channel base+1 (mod NUM_IRQ) ranks highest.
module rotating_priority_encoder
   import pic_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8,
   parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] vec,
   input  logic [ID_W-1:0]    base,
   output logic               found,
   output logic [ID_W-1:0]    index
);

   logic [NUM_IRQ-1:0] rot;
   int unsigned        pos;

   assign rot = NUM_IRQ'(rot_left(32'(vec), 32'(base), NUM_IRQ));

   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = 0;
      // Walk from lowest to highest priority so the last hit is the winner.
      for (int j = NUM_IRQ - 1; j >= 0; j--) begin
         if (rot[j[ID_W-1:0]]) begin
            found = 1'b1;
            pos   = 32'(base) + 1 + 32'(j);
            if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
            index = pos[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/irq_priority_arbiter.sv
// PIC priority resolver: in-service register, rotating priority base, request/ack FSM.
module irq_priority_arbiter
   import pic_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 8,
   parameter int unsigned ID_W        = $clog2(NUM_IRQ),
   parameter int unsigned SPURIOUS_ID = NUM_IRQ - 1
) (
   input  logic                 clock,
   input  logic                 reset,
   irq_priority_arbiter_if.slave bus
);

   state_e             state_q;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [ID_W-1:0]    base_q, base_d;
   logic               int_out_q, vector_valid_q;
   logic [ID_W-1:0]    vector_id_q;

   logic [NUM_IRQ-1:0] cand, blk, allowed, win_vec, eoi_clear, ack_set;
   logic               win_found, isr_found, ack_ok, eoi_lvl_ok, prio_lvl_ok, seen;
   logic [ID_W-1:0]    win_idx, isr_idx;
   int unsigned        ch;

   assign cand        = bus.irr & ~bus.imr & ~isr_q;
   assign blk         = isr_q & ~bus.imr;
   assign ack_ok      = bus.ack && (state_q != ACKD);
   assign eoi_lvl_ok  = 32'(bus.eoi_level) < NUM_IRQ;
   assign prio_lvl_ok = 32'(bus.priority_level) < NUM_IRQ;

   // Fully nested: only channels ranked strictly above the top unmasked in-service bit survive.
   always_comb begin
      allowed = '1;
      seen    = 1'b0;
      ch      = 0;
      if (!bus.special_mask_mode) begin
         for (int unsigned j = 0; j < NUM_IRQ; j++) begin
            ch = 32'(base_q) + 1 + j;
            if (ch >= NUM_IRQ) ch = ch - NUM_IRQ;
            seen = seen | blk[ch[ID_W-1:0]];
            allowed[ch[ID_W-1:0]] = ~seen;
         end
      end
   end

   assign win_vec = cand & allowed;

   rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_win_enc (
      .vec   (win_vec),
      .base  (base_q),
      .found (win_found),
      .index (win_idx)
   );

   rotating_priority_encoder #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_enc (
      .vec   (isr_q),
      .base  (base_q),
      .found (isr_found),
      .index (isr_idx)
   );

   // All same-cycle commands act on pre-cycle isr/base; later assignments take precedence.
   always_comb begin
      eoi_clear = '0;
      ack_set   = '0;
      base_d    = base_q;
      if (bus.eoi_specific) begin
         if (eoi_lvl_ok) eoi_clear[bus.eoi_level] = 1'b1;
      end else if (bus.eoi_nonspecific && isr_found) begin
         eoi_clear[isr_idx] = 1'b1;
      end
      if (ack_ok && win_found && !bus.auto_eoi) ack_set[win_idx] = 1'b1;
      isr_d = (isr_q & ~eoi_clear) | ack_set;

      if (ack_ok && win_found && bus.auto_eoi && bus.auto_rotate) base_d = win_idx;
      if (bus.rotate_on_eoi) begin
         if (bus.eoi_specific) begin
            if (eoi_lvl_ok) base_d = bus.eoi_level;
         end else if (bus.eoi_nonspecific && isr_found) begin
            base_d = isr_idx;
         end
      end
      if (bus.set_priority && prio_lvl_ok) base_d = bus.priority_level;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         isr_q          <= '0;
         base_q         <= ID_W'(NUM_IRQ - 1);
         int_out_q      <= 1'b0;
         vector_valid_q <= 1'b0;
         vector_id_q    <= '0;
      end else begin
         isr_q          <= isr_d;
         base_q         <= base_d;
         vector_valid_q <= 1'b0;
         if (ack_ok) begin
            vector_valid_q <= 1'b1;
            vector_id_q    <= win_found ? win_idx : ID_W'(SPURIOUS_ID);
            int_out_q      <= 1'b0;
            state_q        <= ACKD;
         end else begin
            case (state_q)
               IDLE: begin
                  if (win_found) begin
                     state_q   <= REQ;
                     int_out_q <= 1'b1;
                  end
               end
               REQ: begin
                  if (!win_found) begin
                     state_q   <= IDLE;
                     int_out_q <= 1'b0;
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  int_out_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.int_out       = int_out_q;
   assign bus.vector_valid  = vector_valid_q;
   assign bus.vector_id     = vector_id_q;
   assign bus.isr           = isr_q;
   assign bus.priority_base = base_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench for irq_priority_arbiter: stimulus queues expected ack results, a monitor checks them.
module tb_irq_priority_arbiter;

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] isr;
   } exp_t;

   logic clock;
   logic reset;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   irq_priority_arbiter_if #(.NUM_IRQ(8)) bus ();

   irq_priority_arbiter #(.NUM_IRQ(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_ack(input logic [2:0] id, input logic [7:0] isr_exp);
      sb.push_back('{id: id, isr: isr_exp});
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
   endtask

   // Monitor: every vector_valid pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && bus.vector_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_vector", {29'd0, bus.vector_id}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("vector_id", {29'd0, bus.vector_id}, {29'd0, e.id});
               check("isr_at_ack", {24'd0, bus.isr}, {24'd0, e.isr});
            end
         end
      end
   end

   initial begin
      reset                 = 1'b1;
      bus.irr               = '0;
      bus.imr               = '0;
      bus.special_mask_mode = 1'b0;
      bus.auto_eoi          = 1'b0;
      bus.auto_rotate       = 1'b0;
      bus.rotate_on_eoi     = 1'b0;
      bus.eoi_nonspecific   = 1'b0;
      bus.eoi_specific      = 1'b0;
      bus.eoi_level         = '0;
      bus.set_priority      = 1'b0;
      bus.priority_level    = '0;
      bus.ack               = 1'b0;
      step();
      step();
      check("rst_int_out", {31'd0, bus.int_out}, 32'd0);
      check("rst_vvalid", {31'd0, bus.vector_valid}, 32'd0);
      check("rst_isr", {24'd0, bus.isr}, 32'd0);
      check("rst_base", {29'd0, bus.priority_base}, 32'd7);
      reset = 1'b0;
      step();

      // Basic request, one-cycle int_out latency, ack of ch2.
      bus.irr = 8'h24;
      check("int_out_latency0", {31'd0, bus.int_out}, 32'd0);
      step();
      check("int_out_raise", {31'd0, bus.int_out}, 32'd1);
      pulse_ack(3'd2, 8'h04);
      check("int_out_after_ack", {31'd0, bus.int_out}, 32'd0);
      bus.irr = '0;
      step();
      step();
      check("isr_after_ack", {24'd0, bus.isr}, 32'h04);

      // Fully nested: ch3 blocked by in-service ch2, ch0 passes.
      bus.irr = 8'h08;
      step();
      step();
      check("nested_block", {31'd0, bus.int_out}, 32'd0);
      bus.irr = 8'h09;
      step();
      check("nested_ch0", {31'd0, bus.int_out}, 32'd1);
      // Special mask: ch0 then ch3.
      bus.special_mask_mode = 1'b1;
      pulse_ack(3'd0, 8'h05);
      bus.irr = 8'h08;
      step();
      step();
      check("smm_ch3_raise", {31'd0, bus.int_out}, 32'd1);
      pulse_ack(3'd3, 8'h0D);
      bus.irr = '0;
      bus.special_mask_mode = 1'b0;

      // EOI handling and rotation.
      bus.eoi_specific = 1'b1;
      bus.eoi_level    = 3'd0;
      step();
      bus.eoi_specific = 1'b0;
      check("eoi_spec_isr", {24'd0, bus.isr}, 32'h0C);
      check("eoi_spec_base", {29'd0, bus.priority_base}, 32'd7);
      bus.eoi_nonspecific = 1'b1;
      bus.rotate_on_eoi   = 1'b1;
      step();
      bus.eoi_nonspecific = 1'b0;
      bus.rotate_on_eoi   = 1'b0;
      check("eoi_ns_isr", {24'd0, bus.isr}, 32'h08);
      check("eoi_ns_base", {29'd0, bus.priority_base}, 32'd2);
      bus.eoi_specific = 1'b1;
      bus.eoi_level    = 3'd3;
      step();
      bus.eoi_specific = 1'b0;
      check("eoi_clear_all", {24'd0, bus.isr}, 32'h00);
      bus.irr = 8'h0A;
      step();
      check("rot_raise", {31'd0, bus.int_out}, 32'd1);
      pulse_ack(3'd3, 8'h08);
      bus.irr = 8'h02;
      step();
      step();
      check("rot_nested_block", {31'd0, bus.int_out}, 32'd0);
      check("rot_base_hold", {29'd0, bus.priority_base}, 32'd2);
      bus.irr = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      // Auto-EOI with auto-rotate walks all channels in order.
      bus.auto_eoi    = 1'b1;
      bus.auto_rotate = 1'b1;
      bus.irr         = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         pulse_ack(3'(i), 8'h00);
         step();
      end
      check("auto_rot_base", {29'd0, bus.priority_base}, 32'd7);
      check("auto_rot_isr", {24'd0, bus.isr}, 32'h00);
      bus.auto_eoi    = 1'b0;
      bus.auto_rotate = 1'b0;
      bus.irr         = '0;
      step();
      step();

      // Request withdrawn before ack, then a spurious ack.
      bus.irr = 8'h10;
      step();
      check("wd_raise", {31'd0, bus.int_out}, 32'd1);
      bus.irr = '0;
      step();
      check("wd_drop", {31'd0, bus.int_out}, 32'd0);
      pulse_ack(3'd7, 8'h00);
      bus.set_priority   = 1'b1;
      bus.priority_level = 3'd3;
      step();
      check("set_prio_base", {29'd0, bus.priority_base}, 32'd3);
      bus.priority_level = 3'd7;
      step();
      bus.set_priority = 1'b0;
      check("set_prio_restore", {29'd0, bus.priority_base}, 32'd7);

      // Same-cycle ack and specific EOI.
      bus.irr = 8'h04;
      step();
      pulse_ack(3'd2, 8'h04);
      bus.irr = '0;
      step();
      bus.irr          = 8'h02;
      bus.eoi_specific = 1'b1;
      bus.eoi_level    = 3'd2;
      pulse_ack(3'd1, 8'h02);
      bus.eoi_specific = 1'b0;
      check("same_cycle_isr", {24'd0, bus.isr}, 32'h02);

      // Reset in the middle of an ack cycle.
      bus.irr = 8'h01;
      step();
      step();
      check("pre_rst_raise", {31'd0, bus.int_out}, 32'd1);
      bus.ack = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_int_out", {31'd0, bus.int_out}, 32'd0);
      check("mid_rst_vvalid", {31'd0, bus.vector_valid}, 32'd0);
      check("mid_rst_vid", {29'd0, bus.vector_id}, 32'd0);
      check("mid_rst_isr", {24'd0, bus.isr}, 32'd0);
      check("mid_rst_base", {29'd0, bus.priority_base}, 32'd7);
      bus.ack = 1'b0;
      bus.irr = '0;
      step();
      reset = 1'b0;
      step();
      step();
      check("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
